wr_ptr_ctrl: RTL

Parametrised write-side pointer controller for the asynchronous FIFO, the next generation of the plain write-pointer counter. It keeps the binary and Gray write pointers in the write clock domain and generates the RAM write strobe and address. It compares its own pointer against the read pointer, already synchronised into the write domain, to produce registered `full`, `almost_full` and fill-level outputs, plus a sticky overflow flag. It sits between the FIFO write port, the dual-port RAM and the Gray-pointer synchroniser feeding the read domain.

---
 rtl/wr_ptr_ctrl.sv | 78 +++++++
 1 files changed

// File: rtl/wr_ptr_ctrl.sv
// Write-side pointer controller for an asynchronous FIFO: binary/Gray write pointers,
// RAM write strobe/address, registered full/almost_full/level and a sticky overflow flag.
module wr_ptr_ctrl #(
  parameter int unsigned PTR_LEN      = 8,
  parameter int unsigned AFULL_THRESH = (2 ** PTR_LEN) - 2
) (
  input  logic             wclk,
  input  logic             wr_rst,
  input  logic             wr_en,
  input  logic [PTR_LEN:0] rd_ptr_gray_sync,
  input  logic             ovf_clr,
  output logic             wr_fire,
  output logic [PTR_LEN-1:0] waddr,
  output logic [PTR_LEN:0] wrt_ptr,
  output logic [PTR_LEN:0] wrt_ptr_gray,
  output logic             full,
  output logic             almost_full,
  output logic [PTR_LEN:0] wr_level,
  output logic             overflow
);

  localparam logic [PTR_LEN:0] AfThresh = (PTR_LEN + 1)'(AFULL_THRESH);

  logic [PTR_LEN:0] wbin_nxt;
  logic [PTR_LEN:0] wgray_nxt;
  logic [PTR_LEN:0] rbin;
  logic [PTR_LEN:0] full_mask;
  logic [PTR_LEN:0] level_nxt;
  logic             full_nxt;
  logic             almost_full_nxt;
  logic             overflow_nxt;

  assign wr_fire = wr_en & ~full;
  assign waddr   = wrt_ptr[PTR_LEN-1:0];

  always_comb begin
    wbin_nxt  = wrt_ptr + {{PTR_LEN{1'b0}}, wr_fire};
    wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1);

    // Gray to binary: XOR prefix from the MSB down.
    rbin          = '0;
    rbin[PTR_LEN] = rd_ptr_gray_sync[PTR_LEN];
    for (int i = int'(PTR_LEN) - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rd_ptr_gray_sync[i];
    end

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    full_mask            = '0;
    full_mask[PTR_LEN]   = 1'b1;
    full_mask[PTR_LEN-1] = 1'b1;
    full_nxt             = (wgray_nxt == (rd_ptr_gray_sync ^ full_mask));

    level_nxt       = wbin_nxt - rbin;
    almost_full_nxt = (level_nxt >= AfThresh);

    // Set wins over clear.
    overflow_nxt = (wr_en & full) | (overflow & ~ovf_clr);
  end

  always_ff @(posedge wclk or posedge wr_rst) begin
    if (wr_rst) begin
      wrt_ptr      <= '0;
      wrt_ptr_gray <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      wr_level     <= '0;
      overflow     <= 1'b0;
    end else begin
      wrt_ptr      <= wbin_nxt;
      wrt_ptr_gray <= wgray_nxt;
      full         <= full_nxt;
      almost_full  <= almost_full_nxt;
      wr_level     <= level_nxt;
      overflow     <= overflow_nxt;
    end
  end

endmodule
